// File: rtl/seq_mul_gen.sv
// ============================================================================
// Module   : seq_mul_gen
// Brief    : Shift-add WIDTH x WIDTH multiplier, signed/unsigned, early exit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_mul_gen #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               LOAD,
  input  logic               SIGNED,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Wait,
  output logic               Ready,
  output logic [2*WIDTH-1:0] result
);

  localparam int PROD_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PROD_W-1:0]   r_acc;
  logic [PROD_W-1:0]   r_mcand;
  logic [WIDTH-1:0]    r_mplier;
  logic                r_neg;
  logic                r_ready;
  logic [PROD_W-1:0]   r_result;

  logic [WIDTH-1:0]    w_a_mag;
  logic [WIDTH-1:0]    w_b_mag;
  logic                w_neg;
  logic [PROD_W-1:0]   w_acc_add;
  logic [PROD_W-1:0]   w_final;

  // Most-negative operand negates to 2^(WIDTH-1), which is still exact unsigned.
  assign w_a_mag   = (SIGNED && A[WIDTH-1]) ? -A : A;
  assign w_b_mag   = (SIGNED && B[WIDTH-1]) ? -B : B;
  assign w_neg     = SIGNED & (A[WIDTH-1] ^ B[WIDTH-1]);
  assign w_acc_add = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_final   = r_neg ? -r_acc : r_acc;

  assign Ready  = r_ready;
  assign result = r_result;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    Wait        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (LOAD) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        Wait = 1'b1;
        if (r_mplier == '0) begin
          w_state_nxt = ST_FIN;
        end
      end
      ST_FIN: begin
        Wait        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_neg    <= 1'b0;
      r_ready  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (LOAD) begin
            r_acc    <= '0;
            r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
            r_mplier <= w_b_mag;
            r_neg    <= w_neg;
            r_ready  <= 1'b0;
          end
        end
        ST_RUN: begin
          // Stop shifting once no multiplier bits remain; FIN follows next edge.
          if (r_mplier != '0) begin
            r_acc    <= w_acc_add;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
          end
        end
        ST_FIN: begin
          r_result <= w_final;
          r_ready  <= 1'b1;
        end
        default: begin
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_mul_gen.sv
// ============================================================================
// Module   : tb_seq_mul_gen
// Brief    : Directed self-checking bench for seq_mul_gen (WIDTH 16 and 8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_mul_gen;

  logic        CLK;
  logic        RESET;

  logic        LOAD16, SIGNED16;
  logic [15:0] A16, B16;
  logic        Wait16, Ready16;
  logic [31:0] result16;

  logic        LOAD8, SIGNED8;
  logic [7:0]  A8, B8;
  logic        Wait8, Ready8;
  logic [15:0] result8;

  int n_tests = 0;
  int n_fail  = 0;

  seq_mul_gen #(.WIDTH(16)) u_dut16 (
    .CLK    (CLK),
    .RESET  (RESET),
    .LOAD   (LOAD16),
    .SIGNED (SIGNED16),
    .A      (A16),
    .B      (B16),
    .Wait   (Wait16),
    .Ready  (Ready16),
    .result (result16)
  );

  seq_mul_gen #(.WIDTH(8)) u_dut8 (
    .CLK    (CLK),
    .RESET  (RESET),
    .LOAD   (LOAD8),
    .SIGNED (SIGNED8),
    .A      (A8),
    .B      (B8),
    .Wait   (Wait8),
    .Ready  (Ready8),
    .result (result8)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run16(input string tag, input logic sg, input logic [15:0] a,
                       input logic [15:0] b, input logic [31:0] exp_r, input int exp_lat);
    int cyc;
    @(negedge CLK);
    SIGNED16 = sg; A16 = a; B16 = b; LOAD16 = 1'b1;
    @(posedge CLK); #1;
    LOAD16 = 1'b0;
    check({tag, " wait_after_accept"}, Wait16, 1);
    check({tag, " ready_cleared"}, Ready16, 0);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (Ready16) break;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, result16, exp_r);
    check({tag, " wait_low"}, Wait16, 0);
  endtask

  task automatic run8(input string tag, input logic sg, input logic [7:0] a,
                      input logic [7:0] b, input logic [15:0] exp_r, input int exp_lat);
    int cyc;
    @(negedge CLK);
    SIGNED8 = sg; A8 = a; B8 = b; LOAD8 = 1'b1;
    @(posedge CLK); #1;
    LOAD8 = 1'b0;
    check({tag, " wait_after_accept"}, Wait8, 1);
    cyc = 0;
    while (cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (Ready8) break;
    end
    check({tag, " latency"}, cyc, exp_lat);
    check({tag, " result"}, result8, exp_r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    RESET = 1'b0;
    LOAD16 = 1'b0; SIGNED16 = 1'b0; A16 = '0; B16 = '0;
    LOAD8  = 1'b0; SIGNED8  = 1'b0; A8  = '0; B8  = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset wait16", Wait16, 0);
    check("reset ready16", Ready16, 0);
    check("reset result16", result16, 0);
    check("reset ready8", Ready8, 0);
    @(negedge CLK);
    RESET = 1'b1;

    // Unsigned full-scale, signed corner cases, zero multiplier
    run16("u_ffff_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 18);
    run16("s_m3_x5",     1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1, 5);
    run16("s_min_min",   1'b1, 16'h8000, 16'h8000, 32'h40000000, 18);
    run16("s_min_x1",    1'b1, 16'h8000, 16'h0001, 32'hFFFF8000, 3);
    run16("b_zero",      1'b0, 16'h1234, 16'h0000, 32'h00000000, 2);
    run16("s_neg_x0",    1'b1, 16'hFFFF, 16'h0000, 32'h00000000, 2);
    run16("u_3_x4",      1'b0, 16'h0003, 16'h0004, 32'h0000000C, 5);

    // LOAD while busy is ignored
    @(negedge CLK);
    SIGNED16 = 1'b0; A16 = 16'd7; B16 = 16'd9; LOAD16 = 1'b1;
    @(posedge CLK); #1;
    LOAD16 = 1'b0;
    cyc = 0;
    repeat (2) begin @(posedge CLK); #1; cyc++; end
    A16 = 16'd1; B16 = 16'd1; LOAD16 = 1'b1;
    @(posedge CLK); #1; cyc++;
    LOAD16 = 1'b0;
    check("busy_load wait", Wait16, 1);
    check("busy_load ready", Ready16, 0);
    while (cyc < 40) begin
      @(posedge CLK); #1;
      cyc++;
      if (Ready16) break;
    end
    check("busy_load latency", cyc, 6);
    check("busy_load result", result16, 63);
    repeat (3) @(posedge CLK);
    #1;
    check("hold ready", Ready16, 1);
    check("hold result", result16, 63);

    // New accept clears Ready but keeps the old result until FIN
    A16 = 16'd2; B16 = 16'd3; LOAD16 = 1'b1;
    @(posedge CLK); #1;
    LOAD16 = 1'b0;
    check("reaccept ready", Ready16, 0);
    check("reaccept result_kept", result16, 63);

    // Asynchronous reset mid-run
    @(posedge CLK); #2;
    RESET = 1'b0;
    #1;
    check("async wait", Wait16, 0);
    check("async ready", Ready16, 0);
    check("async result", result16, 0);
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("post_reset idle", Wait16, 0);
    run16("after_reset_2x3", 1'b0, 16'd2, 16'd3, 32'd6, 4);

    // 8-bit instance
    run8("w8_u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 10);
    run8("w8_s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001, 3);
    run8("w8_s_80_7f", 1'b1, 8'h80, 8'h7F, 16'hC080, 9);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_mul_gen.md
Name: seq_mul_gen

Overview:
- Parametrised sequential shift-add multiplier for WIDTH x WIDTH operands, producing a 2*WIDTH product.
- Adds a runtime signed/unsigned mode, a strict load handshake (busy rejection, held result) and early termination when no multiplier bits remain.
- Sits beside the datapath as a shared, multi-cycle arithmetic unit driven by a simple controller.

Parameters:
WIDTH, 16, operand width in bits (>= 2); product width is 2*WIDTH

Ports:
CLK  input  1  clock, rising edge
RESET  input  1  asynchronous, active-low reset
LOAD  input  1  start request; sampled on rising CLK
SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with LOAD
A  input  WIDTH  multiplicand; sampled with LOAD
B  input  WIDTH  multiplier; sampled with LOAD
Wait  output  1  high while an operation is in progress
Ready  output  1  high while result holds a valid product
result  output  2*WIDTH  product register

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-low.
- Reset (RESET=0, any time, including mid-operation):
  - state=IDLE; all internal registers cleared.
  - Wait=0, Ready=0, result=0.
  - Operation restarts only on a new LOAD after RESET returns high.
- States:
  - IDLE: Wait=0.
  - RUN: Wait=1.
  - FIN: Wait=1.
- Accept (edge k): LOAD=1 in IDLE. At this edge:
  - Captures magnitudes |A| and |B| as WIDTH-bit unsigned values. In unsigned mode these are A and B unchanged.
  - In signed mode, the most-negative value maps to 2^(WIDTH-1), which fits.
  - neg = SIGNED & (A[msb] ^ B[msb]).
  - Accumulator cleared; multiplicand register is 2*WIDTH wide.
  - Ready cleared; result retains its old value; state -> RUN.
- LOAD in RUN or FIN is ignored. No state, operand or output change.
- RUN, each edge:
  - If B_reg == 0: no add; state -> FIN.
  - Else: if B_reg[0], acc += A_reg (2*WIDTH bits, carry discarded, cannot overflow). Then A_reg <<= 1, B_reg >>= 1.
- FIN edge:
  - result = neg ? (-acc mod 2^(2*WIDTH)) : acc.
  - Ready=1; state -> IDLE.
- Latency: let p = index of the highest set bit of |B| (p = -1 if |B|=0).
  - Wait rises after edge k.
  - Ready rises after edge k+p+3, and Wait falls at the same edge.
  - WIDTH=16, B=0xFFFF unsigned: 18 cycles.
  - B=0: 2 cycles.
- Back-to-back: LOAD may be asserted in the first IDLE cycle after Ready rises and is accepted at that edge.
- Ready stays high, with result stable, until the next accepted LOAD or reset.
- A product of zero is never negated; -0 = 0.

Test Plan:
1. WIDTH=16, SIGNED=0, A=0xFFFF, B=0xFFFF, LOAD pulse -> Wait high 18 cycles, then Ready=1, result=0xFFFE0001.
2. WIDTH=16, SIGNED=1 with A=0xFFFD (-3), B=0x0005 -> result=0xFFFFFFF1. A=0x8000, B=0x8000 -> result=0x40000000. A=0x8000, B=0x0001 -> result=0xFFFF8000.
3. A=0x1234, B=0x0000 -> Ready after 2 cycles, result=0. Then A=0x0003, B=0x0004 -> Ready after 5 cycles, result=0x0000000C.
4. Start A=7, B=9. Assert LOAD with A=1, B=1 at cycle 3 of RUN -> ignored; result=63 at normal latency. Ready remains set until the next LOAD, which clears Ready on its accept edge.
5. Drop RESET asynchronously mid-RUN (between clock edges) -> Wait, Ready and result go to 0 immediately. A subsequent LOAD A=2, B=3 -> result=6.
6. WIDTH=8 instance: SIGNED=0, 0xFF x 0xFF -> 0xFE01. SIGNED=1, 0xFF x 0xFF -> 0x0001. SIGNED=1, 0x80 x 0x7F -> 0xC080.
